hdmi_audio_sample_packetizer: RTL and testbench

Sits between the audio sample AsyncFifo (pixelClock read side) and the HDMI data-island packet scheduler. Pops stereo 16-bit PCM samples from the FIFO and groups 1..4 of them into an HDMI Audio Sample Packet (header plus four 56-bit subpackets). Generates the IEC 60958 192-frame block framing, channel-status, validity, user and parity bits. Holds each finished packet under a valid/ready handshake until the scheduler takes it.

---
 rtl/hdmi_audio_pkg.sv | 42 ++++
 rtl/iec60958_status_bit.sv | 39 +++
 rtl/hdmi_audio_sample_packetizer.sv | 164 ++++++++++++++++
 tb/tb_hdmi_audio_sample_packetizer.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_audio_pkg.sv
// rtl/hdmi_audio_pkg.sv - shared constants, state type and parity helper for the HDMI audio packetizer
package hdmi_audio_pkg;

    localparam logic [7:0] AUDIO_SAMPLE_PACKET = 8'h02;
    localparam int         IEC60958_BLOCK_FRAMES = 192;
    localparam logic [7:0] LAST_FRAME_INDEX = 8'(IEC60958_BLOCK_FRAMES - 1);

    // Channel-status field offsets within the 192-bit block
    localparam logic [7:0] CS_CATEGORY_LSB    = 8'd8;
    localparam logic [7:0] CS_CHANNEL_LSB     = 8'd20;
    localparam logic [7:0] CS_FREQ_LSB        = 8'd24;
    localparam logic [7:0] CS_WORD_LENGTH_LSB = 8'd32;

    localparam logic [3:0] LEFT_CHANNEL_NUMBER  = 4'd1;
    localparam logic [3:0] RIGHT_CHANNEL_NUMBER = 4'd2;

    // Subpacket byte 6 bit positions
    localparam int B6_VL = 0;
    localparam int B6_UL = 1;
    localparam int B6_CL = 2;
    localparam int B6_PL = 3;
    localparam int B6_VR = 4;
    localparam int B6_UR = 5;
    localparam int B6_CR = 6;
    localparam int B6_PR = 7;

    localparam logic VALIDITY_BIT = 1'b0;
    localparam logic USER_BIT     = 1'b0;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_READ_WAIT,
        ST_OFFER
    } packetizerState_t;

    // The low 8 bits of the 24-bit field are zero, so they do not change parity
    function automatic logic evenParity(input logic [15:0] sample, input logic v, input logic u,
                                        input logic c);
        return ^{sample, v, u, c};
    endfunction

endpackage

// File: rtl/iec60958_status_bit.sv
// rtl/iec60958_status_bit.sv - IEC 60958 consumer channel-status bit for one frame and channel
module iec60958_status_bit
    import hdmi_audio_pkg::*;
(
    input  logic [7:0] frameIndex,
    input  logic       rightChannel,
    input  logic [7:0] categoryCode,
    input  logic [3:0] samplingFreq,
    input  logic [3:0] wordLength,
    output logic       statusBit
);

    logic [7:0] categoryOffset;
    logic [7:0] channelOffset;
    logic [7:0] freqOffset;
    logic [7:0] lengthOffset;
    logic [3:0] channelNumber;

    // Frames below a field's base wrap to large offsets and fall outside the field
    assign categoryOffset = frameIndex - CS_CATEGORY_LSB;
    assign channelOffset  = frameIndex - CS_CHANNEL_LSB;
    assign freqOffset     = frameIndex - CS_FREQ_LSB;
    assign lengthOffset   = frameIndex - CS_WORD_LENGTH_LSB;
    assign channelNumber  = rightChannel ? RIGHT_CHANNEL_NUMBER : LEFT_CHANNEL_NUMBER;

    always_comb begin
        statusBit = 1'b0;
        if (categoryOffset < 8'd8) begin
            statusBit = categoryCode[categoryOffset[2:0]];
        end else if (channelOffset < 8'd4) begin
            statusBit = channelNumber[channelOffset[1:0]];
        end else if (freqOffset < 8'd4) begin
            statusBit = samplingFreq[freqOffset[1:0]];
        end else if (lengthOffset < 8'd4) begin
            statusBit = wordLength[lengthOffset[1:0]];
        end
    end

endmodule

// File: rtl/hdmi_audio_sample_packetizer.sv
// rtl/hdmi_audio_sample_packetizer.sv - groups FIFO PCM samples into HDMI audio sample packets
module hdmi_audio_sample_packetizer
    import hdmi_audio_pkg::*;
#(
    parameter int SAMPLES_PER_PACKET = 4
) (
    input  logic        pixelClock,
    input  logic        asyncResetN,
    input  logic        sampleFifoEmpty,
    input  logic [31:0] sampleFifoReadData,
    output logic        sampleFifoReadEnable,
    input  logic        flush,
    input  logic [7:0]  spdifCategoryCode,
    input  logic [3:0]  spdifSamplingFreq,
    input  logic [3:0]  spdifWordLength,
    output logic        packetValid,
    input  logic        packetReady,
    output logic [23:0] header,
    output logic [55:0] subpacket0,
    output logic [55:0] subpacket1,
    output logic [55:0] subpacket2,
    output logic [55:0] subpacket3
);

    localparam logic [2:0] SPP_COUNT = 3'(SAMPLES_PER_PACKET);

    packetizerState_t state;
    packetizerState_t stateNext;
    logic [2:0]  count;
    logic [7:0]  frameIndex;
    logic        flushPending;
    logic [55:0] slotData [4];
    logic [3:0]  blockStart;
    logic [3:0]  samplePresent;

    logic popNow;
    logic capture;
    logic accept;

    logic [15:0] leftSample;
    logic [15:0] rightSample;
    logic        leftStatus;
    logic        rightStatus;
    logic [7:0]  byte6;
    logic [55:0] newSubpacket;

    assign leftSample  = sampleFifoReadData[31:16];
    assign rightSample = sampleFifoReadData[15:0];

    iec60958_status_bit leftStatusBit (
        .frameIndex   (frameIndex),
        .rightChannel (1'b0),
        .categoryCode (spdifCategoryCode),
        .samplingFreq (spdifSamplingFreq),
        .wordLength   (spdifWordLength),
        .statusBit    (leftStatus)
    );

    iec60958_status_bit rightStatusBit (
        .frameIndex   (frameIndex),
        .rightChannel (1'b1),
        .categoryCode (spdifCategoryCode),
        .samplingFreq (spdifSamplingFreq),
        .wordLength   (spdifWordLength),
        .statusBit    (rightStatus)
    );

    always_comb begin
        byte6        = '0;
        byte6[B6_VL] = VALIDITY_BIT;
        byte6[B6_UL] = USER_BIT;
        byte6[B6_CL] = leftStatus;
        byte6[B6_PL] = evenParity(leftSample, VALIDITY_BIT, USER_BIT, leftStatus);
        byte6[B6_VR] = VALIDITY_BIT;
        byte6[B6_UR] = USER_BIT;
        byte6[B6_CR] = rightStatus;
        byte6[B6_PR] = evenParity(rightSample, VALIDITY_BIT, USER_BIT, rightStatus);
    end

    assign newSubpacket = {byte6, rightSample, 8'h00, leftSample, 8'h00};

    always_comb begin
        stateNext = state;
        popNow    = 1'b0;
        capture   = 1'b0;
        accept    = 1'b0;
        unique case (state)
            ST_FILL: begin
                // A flush beats a pop so the closing packet never grows by one more sample
                if ((flush || flushPending) && count != 3'd0) begin
                    stateNext = ST_OFFER;
                end else if (!sampleFifoEmpty && count < SPP_COUNT) begin
                    popNow    = 1'b1;
                    stateNext = ST_READ_WAIT;
                end
            end
            ST_READ_WAIT: begin
                capture   = 1'b1;
                stateNext = (count + 3'd1 == SPP_COUNT) ? ST_OFFER : ST_FILL;
            end
            ST_OFFER: begin
                if (packetReady) begin
                    accept    = 1'b1;
                    stateNext = ST_FILL;
                end
            end
            default: stateNext = ST_FILL;
        endcase
    end

    always_ff @(posedge pixelClock or negedge asyncResetN) begin
        if (!asyncResetN) begin
            state        <= ST_FILL;
            count        <= 3'd0;
            frameIndex   <= 8'd0;
            flushPending <= 1'b0;
            blockStart   <= 4'd0;
            for (int n = 0; n < 4; n++) begin
                slotData[n] <= '0;
            end
        end else begin
            state <= stateNext;
            if (capture) begin
                for (int n = 0; n < 4; n++) begin
                    if (count == 3'(n)) begin
                        slotData[n]   <= newSubpacket;
                        blockStart[n] <= (frameIndex == 8'd0);
                    end
                end
                count      <= count + 3'd1;
                frameIndex <= (frameIndex == LAST_FRAME_INDEX) ? 8'd0 : frameIndex + 8'd1;
            end else if (accept) begin
                count      <= 3'd0;
                blockStart <= 4'd0;
                for (int n = 0; n < 4; n++) begin
                    slotData[n] <= '0;
                end
            end
            if (capture && flush) begin
                flushPending <= 1'b1;
            end else if (state == ST_FILL || accept) begin
                flushPending <= 1'b0;
            end
        end
    end

    always_comb begin
        samplePresent = '0;
        for (int n = 0; n < 4; n++) begin
            samplePresent[n] = (3'(n) < count);
        end
    end

    // Gated by reset so the pop strobe is low the instant reset asserts
    assign sampleFifoReadEnable = popNow & asyncResetN;
    assign packetValid          = (state == ST_OFFER);
    assign header     = packetValid ? {blockStart, 4'h0, 4'h0, samplePresent, AUDIO_SAMPLE_PACKET}
                                    : 24'h0;
    assign subpacket0 = packetValid ? slotData[0] : 56'h0;
    assign subpacket1 = packetValid ? slotData[1] : 56'h0;
    assign subpacket2 = packetValid ? slotData[2] : 56'h0;
    assign subpacket3 = packetValid ? slotData[3] : 56'h0;

endmodule

// File: tb/tb_hdmi_audio_sample_packetizer.sv
// tb/tb_hdmi_audio_sample_packetizer.sv - scoreboard bench for hdmi_audio_sample_packetizer
module tb_hdmi_audio_sample_packetizer;

    localparam int SPP = 4;

    logic        pixelClock = 1'b0;
    logic        asyncResetN = 1'b0;
    logic        sampleFifoEmpty = 1'b1;
    logic [31:0] sampleFifoReadData = '0;
    logic        sampleFifoReadEnable;
    logic        flush = 1'b0;
    logic [7:0]  spdifCategoryCode = '0;
    logic [3:0]  spdifSamplingFreq = '0;
    logic [3:0]  spdifWordLength = '0;
    logic        packetValid;
    logic        packetReady = 1'b0;
    logic [23:0] header;
    logic [55:0] subpacket0, subpacket1, subpacket2, subpacket3;

    hdmi_audio_sample_packetizer #(.SAMPLES_PER_PACKET(SPP)) dut (
        .pixelClock           (pixelClock),
        .asyncResetN          (asyncResetN),
        .sampleFifoEmpty      (sampleFifoEmpty),
        .sampleFifoReadData   (sampleFifoReadData),
        .sampleFifoReadEnable (sampleFifoReadEnable),
        .flush                (flush),
        .spdifCategoryCode    (spdifCategoryCode),
        .spdifSamplingFreq    (spdifSamplingFreq),
        .spdifWordLength      (spdifWordLength),
        .packetValid          (packetValid),
        .packetReady          (packetReady),
        .header               (header),
        .subpacket0           (subpacket0),
        .subpacket1           (subpacket1),
        .subpacket2           (subpacket2),
        .subpacket3           (subpacket3)
    );

    always #5 pixelClock = ~pixelClock;

    typedef struct packed {
        logic [31:0] word;
        logic [7:0]  frame;
        logic        cl;
        logic        cr;
    } entry_t;

    typedef struct packed {
        logic [23:0]  hdr;
        logic [223:0] sps;
    } pkt_t;

    logic [31:0] fifoQ [$];
    entry_t      curList [$];
    pkt_t        expQ [$];
    int          bIdx [$];
    int          modelFrame = 0;
    int          compared = 0;
    int          mismatched = 0;
    int          acceptCount = 0;
    logic [23:0] lastHdr;
    logic [55:0] lastSp [4];
    logic        readyRandom = 1'b0;
    logic        forcedReady = 1'b1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Channel-status bit for a frame, assembled as a plain 192-bit block image
    function automatic logic csBit(input int frame, input logic [3:0] chanNum);
        logic [191:0] cs;
        cs = '0;
        cs[15:8]  = spdifCategoryCode;
        cs[23:20] = chanNum;
        cs[27:24] = spdifSamplingFreq;
        cs[35:32] = spdifWordLength;
        return cs[frame];
    endfunction

    function automatic logic [55:0] expSub(input entry_t e);
        logic [15:0] l, r;
        logic pl, pr;
        l  = e.word[31:16];
        r  = e.word[15:0];
        pl = ((($countones(l) + int'(e.cl)) % 2) == 1);
        pr = ((($countones(r) + int'(e.cr)) % 2) == 1);
        return {pr, e.cr, 1'b0, 1'b0, pl, e.cl, 1'b0, 1'b0, r, 8'h00, l, 8'h00};
    endfunction

    task automatic closePacket();
        pkt_t p;
        logic [3:0] b, present;
        p.sps   = '0;
        b       = '0;
        present = '0;
        for (int n = 0; n < curList.size(); n++) begin
            present[n] = 1'b1;
            b[n] = (curList[n].frame == 8'd0);
            p.sps[n*56 +: 56] = expSub(curList[n]);
        end
        p.hdr = {b, 4'h0, 4'h0, present, 8'h02};
        expQ.push_back(p);
        curList.delete();
    endtask

    // Monitor: models the FIFO, tracks pops/flushes and scores accepted packets
    initial begin
        logic        checkDrop;
        logic        popPending;
        logic [31:0] popWord;
        pkt_t        e;
        entry_t      ent;
        checkDrop  = 1'b0;
        popPending = 1'b0;
        popWord    = '0;
        forever begin
            @(negedge pixelClock);
            if (!asyncResetN) begin
                curList.delete();
                expQ.delete();
                modelFrame = 0;
                popPending = 1'b0;
                checkDrop  = 1'b0;
            end else begin
                if (checkDrop) begin
                    check("valid_drop_after_accept", 64'(packetValid), 64'd0);
                    checkDrop = 1'b0;
                end
                if (packetValid && packetReady) begin
                    if (expQ.size() == 0) begin
                        check("unexpected_packet", 64'd1, 64'd0);
                    end else begin
                        e = expQ.pop_front();
                        check("header", 64'(header), 64'(e.hdr));
                        check("subpacket0", 64'(subpacket0), 64'(e.sps[55:0]));
                        check("subpacket1", 64'(subpacket1), 64'(e.sps[111:56]));
                        check("subpacket2", 64'(subpacket2), 64'(e.sps[167:112]));
                        check("subpacket3", 64'(subpacket3), 64'(e.sps[223:168]));
                    end
                    if (header[23:16] != 8'h00) bIdx.push_back(acceptCount);
                    lastHdr   = header;
                    lastSp[0] = subpacket0;
                    lastSp[1] = subpacket1;
                    lastSp[2] = subpacket2;
                    lastSp[3] = subpacket3;
                    acceptCount++;
                    checkDrop = 1'b1;
                end
                if (flush && !packetValid && curList.size() > 0) closePacket();
                if (sampleFifoReadEnable) begin
                    if (fifoQ.size() == 0) begin
                        check("pop_on_empty", 64'd1, 64'd0);
                        popWord = '0;
                    end else begin
                        popWord = fifoQ.pop_front();
                    end
                    popPending = 1'b1;
                    ent.word  = popWord;
                    ent.frame = 8'(modelFrame);
                    ent.cl    = csBit(modelFrame, 4'd1);
                    ent.cr    = csBit(modelFrame, 4'd2);
                    curList.push_back(ent);
                    modelFrame = (modelFrame + 1) % 192;
                    if (curList.size() == SPP) closePacket();
                end
            end
            @(posedge pixelClock);
            #1;
            if (popPending) begin
                sampleFifoReadData = popWord;
                popPending = 1'b0;
            end
            sampleFifoEmpty = (fifoQ.size() == 0);
        end
    end

    initial begin
        forever begin
            @(posedge pixelClock);
            #1;
            packetReady = readyRandom ? ($urandom_range(0, 2) != 0) : forcedReady;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge pixelClock);
        #2;
    endtask

    task automatic pulseFlush();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic doReset();
        tick();
        asyncResetN = 1'b0;
        repeat (3) tick();
        asyncResetN = 1'b1;
    endtask

    task automatic drain();
        int t;
        logic done;
        t = 0;
        done = 1'b0;
        while (t < 4000 && !done) begin
            tick();
            t++;
            flush = (fifoQ.size() == 0 && curList.size() != 0 && (t % 6 == 0));
            done = (fifoQ.size() == 0 && curList.size() == 0 && expQ.size() == 0 && !packetValid
                    && !flush);
        end
        flush = 1'b0;
        check("drain_done", 64'(done), 64'd1);
    endtask

    initial begin
        int base, changes, pops, t;
        logic seen;
        logic [23:0] snapHdr;
        logic [55:0] snap0, snap1, snap2, snap3;

        repeat (3) tick();
        check("reset_valid", 64'(packetValid), 64'd0);
        check("reset_pop", 64'(sampleFifoReadEnable), 64'd0);
        check("reset_header", 64'(header), 64'd0);
        check("reset_subpacket0", 64'(subpacket0), 64'd0);
        asyncResetN = 1'b1;

        // Four identical small samples close one packet by count
        for (int i = 0; i < 4; i++) fifoQ.push_back(32'h0001_0000);
        drain();
        check("t1_header", 64'(lastHdr), 64'h100F02);
        check("t1_subpacket0", 64'(lastSp[0]), 64'h08_0000_00_0001_00);

        // Partial packet closed by flush, then a flush with nothing buffered
        base = acceptCount;
        fifoQ.push_back(32'h1234_8000);
        fifoQ.push_back(32'h7FFF_0003);
        repeat (12) tick();
        check("no_packet_before_flush", 64'(acceptCount - base), 64'd0);
        pulseFlush();
        drain();
        check("flush_hb1", 64'(lastHdr[15:8]), 64'h03);
        check("flush_subpacket2", 64'(lastSp[2]), 64'd0);
        check("flush_subpacket3", 64'(lastSp[3]), 64'd0);
        base = acceptCount;
        pulseFlush();
        repeat (20) tick();
        check("empty_flush_no_packet", 64'(acceptCount - base), 64'd0);

        // Full IEC block plus wrap, with non-default channel status
        doReset();
        spdifCategoryCode = 8'h40;
        spdifSamplingFreq = 4'd2;
        spdifWordLength   = 4'd2;
        bIdx.delete();
        base = acceptCount;
        for (int i = 0; i < 196; i++) fifoQ.push_back($urandom);
        drain();
        check("block_packets", 64'(acceptCount - base), 64'd49);
        check("block_b_count", 64'(bIdx.size()), 64'd2);
        if (bIdx.size() == 2) begin
            check("block_b_first", 64'(bIdx[0] - base), 64'd0);
            check("block_b_last", 64'(bIdx[1] - base), 64'd48);
        end

        // Back-pressure: no pops and stable outputs while the packet is held
        forcedReady = 1'b0;
        for (int i = 0; i < 8; i++) fifoQ.push_back($urandom);
        t = 0;
        while (!packetValid && t < 100) begin
            tick();
            t++;
        end
        check("hold_valid_seen", 64'(packetValid), 64'd1);
        snapHdr = header;
        snap0 = subpacket0;
        snap1 = subpacket1;
        snap2 = subpacket2;
        snap3 = subpacket3;
        changes = 0;
        pops = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (sampleFifoReadEnable) pops++;
            if (header != snapHdr || subpacket0 != snap0 || subpacket1 != snap1
                || subpacket2 != snap2 || subpacket3 != snap3 || !packetValid) changes++;
        end
        check("hold_no_pops", 64'(pops), 64'd0);
        check("hold_no_changes", 64'(changes), 64'd0);
        forcedReady = 1'b1;
        tick();
        forcedReady = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            seen = sampleFifoReadEnable;
        end
        check("pop_resumes", 64'(seen), 64'd1);
        forcedReady = 1'b1;
        drain();

        // Reset while the third sample of a packet is in flight
        for (int i = 0; i < 3; i++) fifoQ.push_back($urandom);
        t = 0;
        while (curList.size() != 3 && t < 50) begin
            tick();
            t++;
        end
        check("reset_setup", 64'(curList.size()), 64'd3);
        asyncResetN = 1'b0;
        #1;
        check("midreset_valid", 64'(packetValid), 64'd0);
        check("midreset_pop", 64'(sampleFifoReadEnable), 64'd0);
        check("midreset_header", 64'(header), 64'd0);
        check("midreset_subpacket0", 64'(subpacket0), 64'd0);
        repeat (3) tick();
        asyncResetN = 1'b1;
        for (int i = 0; i < 4; i++) fifoQ.push_back($urandom);
        drain();
        check("post_reset_header", 64'(lastHdr), 64'h100F02);

        // Randomized traffic, ready and flush timing
        for (int ph = 0; ph < 3; ph++) begin
            spdifCategoryCode = 8'($urandom);
            spdifSamplingFreq = 4'($urandom);
            spdifWordLength   = 4'($urandom);
            readyRandom = 1'b1;
            for (int i = 0; i < 80; i++) begin
                fifoQ.push_back($urandom);
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) tick();
                if ($urandom_range(0, 6) == 0) pulseFlush();
            end
            drain();
            readyRandom = 1'b0;
        end

        check("scoreboard_empty", 64'(expQ.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
